menu_video_timing: RTL

//  Free-running raster timing generator for the MENU core's 640x312 pixel domain.

---
 rtl/menu_video_timing_pkg.sv | 20 ++
 rtl/menu_video_timing_if.sv | 26 ++
 rtl/menu_video_timing_span_flag.sv | 46 ++++
 rtl/menu_video_timing.sv | 127 ++++++++++++
 4 files changed

// File: rtl/menu_video_timing_pkg.sv
// Shared timing defaults and counter types for the MENU 640x312 pixel domain.
package menu_video_pkg;

    localparam int H_TOTAL    = 640;
    localparam int HBL_START  = 310;
    localparam int HBL_END    = 420;
    localparam int HS_START   = 336;
    localparam int HS_END     = 368;
    localparam int V_TOTAL    = 312;
    localparam int VBL_START  = 306;
    localparam int VBL_END    = 2;
    localparam int VS_START   = 308;
    localparam int VS_END     = 0;
    localparam int PHASE_STEP = 6;
    localparam int PHASE_W    = 10;

    typedef logic [9:0] hcnt_t;
    typedef logic [8:0] vcnt_t;

endpackage

// File: rtl/menu_video_timing_if.sv
// Raster outputs bundle: the timing generator drives it, sync/colour consumers read it.
interface menu_video_timing_if #(
    parameter int PHASE_W = 10
);
    import menu_video_pkg::*;

    hcnt_t              hc;
    vcnt_t              vc;
    logic [PHASE_W-1:0] phase;
    logic               hblank;
    logic               vblank;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic               line_start;
    logic               frame_start;

    modport master (
        output hc, vc, phase, hblank, vblank, hsync, vsync, de, line_start, frame_start
    );

    modport slave (
        input hc, vc, phase, hblank, vblank, hsync, vsync, de, line_start, frame_start
    );

endinterface

// File: rtl/menu_video_timing_span_flag.sv
// Set/clear span register: sets when the counter reads SET_AT, clears when it reads
// CLR_AT, both judged on the pre-edge count. CLR_AT < SET_AT wraps through zero.
module span_flag #(
    parameter int   CNT_W   = 10,
    parameter int   SET_AT  = 0,
    parameter int   CLR_AT  = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [CNT_W-1:0] cnt,
    output logic             flag_d,
    output logic             flag_q
);

    if (SET_AT == CLR_AT) begin : g_bad_span
        $error("span_flag: SET_AT and CLR_AT must differ");
    end

    // Next flag value from the span endpoints; holds when ce is low or no endpoint hit.
    always_comb begin
        flag_d = flag_q;
        if (ce) begin
            if (cnt == SET_AT[CNT_W-1:0]) begin
                flag_d = 1'b1;
            end else if (cnt == CLR_AT[CNT_W-1:0]) begin
                flag_d = 1'b0;
            end else begin
                flag_d = flag_q;
            end
        end else begin
            flag_d = flag_q;
        end
    end

    // Flag register with synchronous reset to its idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= RST_VAL;
        end else begin
            flag_q <= flag_d;
        end
    end

endmodule

// File: rtl/menu_video_timing.sv
// Free-running raster timing generator: hc/vc counters, blank/sync spans,
// display enable, line/frame strobes and a per-frame phase accumulator.
module menu_video_timing
    import menu_video_pkg::*;
#(
    parameter int H_TOTAL    = menu_video_pkg::H_TOTAL,
    parameter int HBL_START  = menu_video_pkg::HBL_START,
    parameter int HBL_END    = menu_video_pkg::HBL_END,
    parameter int HS_START   = menu_video_pkg::HS_START,
    parameter int HS_END     = menu_video_pkg::HS_END,
    parameter int V_TOTAL    = menu_video_pkg::V_TOTAL,
    parameter int VBL_START  = menu_video_pkg::VBL_START,
    parameter int VBL_END    = menu_video_pkg::VBL_END,
    parameter int VS_START   = menu_video_pkg::VS_START,
    parameter int VS_END     = menu_video_pkg::VS_END,
    parameter int PHASE_STEP = menu_video_pkg::PHASE_STEP,
    parameter int PHASE_W    = menu_video_pkg::PHASE_W
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ce_pix,
    menu_video_timing_if.master vid
);

    if (H_TOTAL > 1024 || H_TOTAL < 2) begin : g_bad_htotal
        $error("menu_video_timing: H_TOTAL must be 2..1024");
    end
    if (V_TOTAL > 512 || V_TOTAL < 2) begin : g_bad_vtotal
        $error("menu_video_timing: V_TOTAL must be 2..512");
    end

    hcnt_t              hc_q, hc_d;
    vcnt_t              vc_q, vc_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               de_q, de_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               h_last_s, v_last_s;
    logic               hblank_d, hblank_q, vblank_d, vblank_q;
    logic               hsync_d, hsync_q, vsync_d, vsync_q;
    logic               sync_nx_unused_s;

    // Counter advance, phase step on frame wrap, and strobes for the edge that zeroes hc.
    always_comb begin
        h_last_s      = (hc_q == hcnt_t'(H_TOTAL - 1));
        v_last_s      = (vc_q == vcnt_t'(V_TOTAL - 1));
        hc_d          = hc_q;
        vc_d          = vc_q;
        phase_d       = phase_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (ce_pix) begin
            if (h_last_s) begin
                hc_d         = 10'd0;
                line_start_d = 1'b1;
                if (v_last_s) begin
                    vc_d          = 9'd0;
                    phase_d       = phase_q + PHASE_W'(PHASE_STEP);
                    frame_start_d = 1'b1;
                end else begin
                    vc_d = vc_q + 9'd1;
                end
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end else begin
            hc_d = hc_q;
        end
    end

    // Display enable tracks the next-state blank flags so it lands on the same edge.
    always_comb begin
        de_d = de_q;
        if (ce_pix) begin
            de_d = !(hblank_d || vblank_d);
        end else begin
            de_d = de_q;
        end
    end

    // Raster state registers with synchronous restart to the top-left pixel.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hc_q          <= 10'd0;
            vc_q          <= 9'd0;
            phase_q       <= '0;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            phase_q       <= phase_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    span_flag #(.CNT_W(10), .SET_AT(HBL_START), .CLR_AT(HBL_END), .RST_VAL(1'b1)) u_hblank (
        .clk(clk_sys), .reset(reset), .ce(ce_pix), .cnt(hc_q), .flag_d(hblank_d), .flag_q(hblank_q)
    );
    span_flag #(.CNT_W(10), .SET_AT(HS_START), .CLR_AT(HS_END), .RST_VAL(1'b0)) u_hsync (
        .clk(clk_sys), .reset(reset), .ce(ce_pix), .cnt(hc_q), .flag_d(hsync_d), .flag_q(hsync_q)
    );
    span_flag #(.CNT_W(9), .SET_AT(VBL_START), .CLR_AT(VBL_END), .RST_VAL(1'b1)) u_vblank (
        .clk(clk_sys), .reset(reset), .ce(ce_pix), .cnt(vc_q), .flag_d(vblank_d), .flag_q(vblank_q)
    );
    span_flag #(.CNT_W(9), .SET_AT(VS_START), .CLR_AT(VS_END), .RST_VAL(1'b0)) u_vsync (
        .clk(clk_sys), .reset(reset), .ce(ce_pix), .cnt(vc_q), .flag_d(vsync_d), .flag_q(vsync_q)
    );

    // Sync next-state values have no consumer here; only blank feeds de.
    assign sync_nx_unused_s = hsync_d ^ vsync_d;

    assign vid.hc          = hc_q;
    assign vid.vc          = vc_q;
    assign vid.phase       = phase_q;
    assign vid.hblank      = hblank_q;
    assign vid.vblank      = vblank_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;

endmodule
